// File: rtl/seq_detector_param.sv
// Programmable serial pattern detector: run-time pattern, length and overlap mode,
// bits qualified by x_valid, registered Moore detect output and a saturating match counter.
module seq_detector_param #(
    parameter int                 MAX_LEN         = 8,
    parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = 8'b0000_1110,
    parameter int                 DEFAULT_LEN     = 4,
    parameter int                 CNT_W           = 8,
    parameter int                 LEN_W           = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               x,
    input  logic               x_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               detected,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat,
    output logic [1:0]         fsm_state
);

    localparam logic [1:0] S_FILL  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_HIT   = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [MAX_LEN-1:0] pattern_q;
    logic [MAX_LEN-1:0] hist_q;
    logic [MAX_LEN-1:0] hist_next;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   fill_q;
    logic [LEN_W-1:0]   fill_next;
    logic [LEN_W-1:0]   len_clamped;
    logic               overlap_q;
    logic               accept;
    logic               match;
    logic [1:0]         state_q;
    logic [1:0]         state_next;
    logic [CNT_W-1:0]   count_q;
    logic               sat_q;

    // A zero length behaves as a single-bit pattern; oversize lengths are clamped.
    always_comb begin
        len_clamped = cfg_len;
        if (cfg_len == '0) begin
            len_clamped = LEN_W'(1);
        end else if (cfg_len > LEN_W'(MAX_LEN)) begin
            len_clamped = LEN_W'(MAX_LEN);
        end
    end

    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
    end

    assign accept    = x_valid && !cfg_load;
    assign hist_next = {hist_q[MAX_LEN-2:0], x};
    assign fill_next = (fill_q == len_q) ? len_q : fill_q + LEN_W'(1);
    assign match     = accept && (fill_next == len_q)
                       && (((hist_next ^ pattern_q) & len_mask) == '0);

    always_comb begin
        state_next = state_q;
        if (accept) begin
            if (match) begin
                state_next = S_HIT;
            end else if (fill_next == len_q) begin
                state_next = S_ARMED;
            end else begin
                state_next = S_FILL;
            end
        end else if (state_q == S_HIT) begin
            // Without overlap the match emptied the history, so hunting restarts from FILL.
            state_next = overlap_q ? S_ARMED : S_FILL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_q <= DEFAULT_PATTERN;
            len_q     <= LEN_W'(DEFAULT_LEN);
            overlap_q <= 1'b1;
            hist_q    <= '0;
            fill_q    <= '0;
            state_q   <= S_FILL;
            count_q   <= '0;
            sat_q     <= 1'b0;
        end else if (cfg_load) begin
            pattern_q <= cfg_pattern;
            len_q     <= len_clamped;
            overlap_q <= cfg_overlap;
            hist_q    <= '0;
            fill_q    <= '0;
            state_q   <= S_FILL;
            count_q   <= '0;
            sat_q     <= 1'b0;
        end else begin
            state_q <= state_next;
            if (accept) begin
                hist_q <= hist_next;
                fill_q <= (match && !overlap_q) ? '0 : fill_next;
            end
            if (match && !sat_q) begin
                count_q <= count_q + CNT_W'(1);
                if (count_q == CNT_MAX - CNT_W'(1)) begin
                    sat_q <= 1'b1;
                end
            end
        end
    end

    assign detected    = (state_q == S_HIT);
    assign match_count = count_q;
    assign count_sat   = sat_q;
    assign fsm_state   = state_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: a default instance and a 2-bit-counter instance share
// stimulus; outputs are compared with a queue-based model, a vector table and scenario counts.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       x = 1'b0;
    logic       x_valid = 1'b0;
    logic       cfg_load = 1'b0;
    logic       cfg_overlap = 1'b1;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;

    logic       det_a, sat_a, det_b, sat_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
    logic [1:0] st_a, st_b;

    int n_pass = 0;
    int n_total = 0;
    int pulses = 0;

    // Reference model: the accepted bits still eligible for a match, newest last.
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ov;
    bit         m_bits[$];
    int         m_cnt;
    bit         m_det;

    typedef struct {
        bit rs;
        bit xb;
        bit v;
        bit det;
        int cnt;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    seq_detector_param dut_a (
        .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .detected(det_a), .match_count(cnt_a), .count_sat(sat_a), .fsm_state(st_a)
    );

    seq_detector_param #(.CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .detected(det_b), .match_count(cnt_b), .count_sat(sat_b), .fsm_state(st_b)
    );

    function automatic int cap(int c, int mx);
        return (c > mx) ? mx : c;
    endfunction

    function automatic vec_t mk(bit rs, bit xb, bit v, bit det, int cnt);
        vec_t t;
        t.rs = rs; t.xb = xb; t.v = v; t.det = det; t.cnt = cnt;
        return t;
    endfunction

    function automatic void model_reset();
        m_pat = 8'b0000_1110;
        m_len = 4;
        m_ov  = 1'b1;
        m_bits.delete();
        m_cnt = 0;
        m_det = 1'b0;
    endfunction

    function automatic void model_step(bit xb, bit v, bit ld, logic [7:0] pat, int len, bit ov);
        bit ok;
        m_det = 1'b0;
        if (ld) begin
            m_pat = pat;
            m_len = (len == 0) ? 1 : ((len > 8) ? 8 : len);
            m_ov  = ov;
            m_bits.delete();
            m_cnt = 0;
        end else if (v) begin
            m_bits.push_back(xb);
            if (m_bits.size() > m_len) void'(m_bits.pop_front());
            if (m_bits.size() == m_len) begin
                ok = 1'b1;
                for (int i = 0; i < m_len; i++) begin
                    if (m_bits[m_len - 1 - i] != m_pat[i]) ok = 1'b0;
                end
                if (ok) begin
                    m_det = 1'b1;
                    m_cnt++;
                    if (!m_ov) m_bits.delete();
                end
            end
        end
    endfunction

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic check_outputs();
        chk("detected", det_a, m_det);
        chk("match_count", cnt_a, cap(m_cnt, 255));
        chk("count_sat", sat_a, m_cnt >= 255);
        chk("detected_w2", det_b, m_det);
        chk("match_count_w2", cnt_b, cap(m_cnt, 3));
        chk("count_sat_w2", sat_b, m_cnt >= 3);
    endtask

    task automatic step(input bit xb, input bit v, input bit ld = 1'b0,
                        input logic [7:0] pat = 8'h00, input logic [3:0] len = 4'd0,
                        input bit ov = 1'b1);
        @(negedge clk);
        x = xb; x_valid = v; cfg_load = ld;
        cfg_pattern = pat; cfg_len = len; cfg_overlap = ov;
        @(posedge clk);
        #1;
        model_step(xb, v, ld, pat, int'(len), ov);
        check_outputs();
        if (det_a) pulses++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; x_valid = 1'b0; cfg_load = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk("reset_detected", det_a, 0);
        chk("reset_count", cnt_a, 0);
        chk("reset_sat", sat_a, 0);
        chk("reset_count_w2", cnt_b, 0);
        pulses = 0;
    endtask

    task automatic stream(input bit b[$]);
        foreach (b[i]) step(b[i], 1'b1);
    endtask

    initial begin
        model_reset();
        do_reset();

        // Defaults: 1,1,1,1,0 -> one pulse after the 5th bit.
        stream('{1, 1, 1, 1, 0});
        chk("pulses_11110", pulses, 1);
        chk("count_11110", cnt_a, 1);
        step(0, 1'b0);
        chk("pulse_width_11110", det_a, 0);

        // Vector table: 111011110 (pulses after bits 4 and 9), then 11011 (none).
        tbl.push_back(mk(1, 1, 1, 0, 0)); tbl.push_back(mk(0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0)); tbl.push_back(mk(0, 0, 1, 1, 1));
        tbl.push_back(mk(0, 1, 1, 0, 1)); tbl.push_back(mk(0, 1, 1, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 1)); tbl.push_back(mk(0, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 2)); tbl.push_back(mk(0, 0, 0, 0, 2));
        tbl.push_back(mk(1, 1, 1, 0, 0)); tbl.push_back(mk(0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0)); tbl.push_back(mk(0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0)); tbl.push_back(mk(0, 0, 0, 0, 0));
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rs) do_reset();
            step(tbl[i].xb, tbl[i].v);
            chk("tbl_detected", det_a, tbl[i].det);
            chk("tbl_count", cnt_a, tbl[i].cnt);
        end

        // Pattern 101, len 3, overlap on then off, stream 10101.
        step(0, 1'b0, 1'b1, 8'b101, 4'd3, 1'b1);
        pulses = 0;
        stream('{1, 0, 1, 0, 1});
        chk("pulses_101_ovl", pulses, 2);
        step(0, 1'b0, 1'b1, 8'b101, 4'd3, 1'b0);
        pulses = 0;
        stream('{1, 0, 1, 0, 1});
        chk("pulses_101_novl", pulses, 1);

        // Defaults, x_valid every 4th clock with x held: 1110 -> one single-cycle pulse.
        do_reset();
        begin
            bit held[4] = '{1, 1, 1, 0};
            for (int i = 0; i < 4; i++) begin
                step(held[i], 1'b1);
                for (int k = 0; k < 3; k++) step(held[i], 1'b0);
            end
        end
        chk("pulses_held", pulses, 1);
        chk("count_held", cnt_a, 1);

        // Pattern 1, len 1: five accepted 1s -> continuous detect, 2-bit counter saturates.
        step(0, 1'b0, 1'b1, 8'h01, 4'd1, 1'b1);
        pulses = 0;
        stream('{1, 1, 1, 1, 1});
        chk("pulses_len1", pulses, 5);
        chk("count_w2_sat", cnt_b, 3);
        chk("sat_w2", sat_b, 1);

        // After 111, cfg_load with a simultaneous valid bit: bit dropped, then 0110 matches once.
        do_reset();
        stream('{1, 1, 1});
        step(1, 1'b1, 1'b1, 8'b0110, 4'd4, 1'b1);
        pulses = 0;
        stream('{1, 1, 0});
        chk("dropped_bit_no_match", pulses, 0);
        do_reset();
        stream('{1, 1, 1});
        step(1, 1'b1, 1'b1, 8'b0110, 4'd4, 1'b1);
        pulses = 0;
        stream('{0, 1, 1, 0});
        chk("pulses_0110", pulses, 1);

        // Reset mid-stream restores the default 1110 pattern; len 0 acts as len 1.
        stream('{0, 1});
        do_reset();
        stream('{1, 1, 1, 0});
        chk("pulses_after_reset", pulses, 1);
        step(0, 1'b0, 1'b1, 8'h00, 4'd0, 1'b0);
        pulses = 0;
        stream('{0, 1, 0});
        chk("pulses_len0", pulses, 2);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
                     8'($urandom_range(0, 255)), 4'($urandom_range(0, 12)),
                     1'($urandom_range(0, 1)));
            end else if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
